// File: rtl/fixed_point_alu.sv
// ----------------------------------------------------------------------------
// fixed_point_alu
//
// Multi-cycle arithmetic core of the calculator. Operates on signed Q9.6
// fixed-point values (16 bits, two's complement, LSB = 1/64) and produces a
// saturated Q9.6 result for the downstream 7-segment decimal converter.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   one-cycle request, sampled only in IDLE (and not while
//                     done is high)
//   op           in   2-bit opcode: 00 add, 01 sub, 10 mul, 11 div
//   operand_a    in   first operand, Q9.6
//   operand_b    in   second operand, Q9.6
//   result       out  registered result, Q9.6
//   busy         out  high from the cycle after acceptance until done
//   done         out  one-cycle pulse when result and flags update
//   overflow     out  result was saturated
//   div_by_zero  out  division with operand_b == 0
//   state_dbg    out  current FSM state (debug visibility)
//
// Handshake: start is a request qualified only by the block being idle.
// When start is high in IDLE and done is low, op/operand_a/operand_b are
// latched on that edge, busy rises and stays high until the edge that
// raises done. done is high for exactly one cycle; result/overflow/
// div_by_zero are valid from that cycle and hold until the next done.
// A start coinciding with done, or arriving while busy, is dropped.
//
// Datapath notes:
//   mul: shift-add on 16-bit magnitudes, one multiplier bit per cycle,
//        16 cycles, 32-bit product, then >> FRAC_BITS.
//   div: restoring division, dividend = |a| << FRAC_BITS, divisor = |b|,
//        one quotient bit per cycle (16 + FRAC_BITS cycles).
//   Sign is applied and saturation performed in FINISH.
// ----------------------------------------------------------------------------
module fixed_point_alu #(
  parameter int          FRAC_BITS = 6,
  parameter logic [15:0] POS_SAT   = 16'h7FFF,
  parameter logic [15:0] NEG_SAT   = 16'h8001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] operand_a,
  input  logic [15:0] operand_b,
  output logic [15:0] result,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        div_by_zero,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Dividend width: 16-bit magnitude with FRAC_BITS zeros appended.
  localparam int DVD_W = 16 + FRAC_BITS;

  localparam logic [4:0] MUL_LAST = 5'd15;
  localparam logic [4:0] DIV_LAST = 5'(DVD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL    = 2'd1,
    S_DIV    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t state;

  // Latched request
  logic [1:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [4:0]  cnt;

  // Multiplier registers
  logic [31:0] mcand;
  logic [15:0] mplier;
  logic [31:0] prod;

  // Divider registers
  logic [15:0]      dsr;
  logic [15:0]      rem;
  logic [DVD_W-1:0] dvd;
  logic [DVD_W-1:0] quo;

  assign state_dbg = state;

  // Magnitudes of the incoming operands; |-32768| = 32768 fits 16 unsigned.
  logic [15:0] mag_a_in;
  logic [15:0] mag_b_in;
  assign mag_a_in = operand_a[15] ? (~operand_a + 16'd1) : operand_a;
  assign mag_b_in = operand_b[15] ? (~operand_b + 16'd1) : operand_b;

  // One restoring-division step. rem < dsr <= 32768, so the shifted
  // remainder needs 17 bits and the kept remainder always fits 16.
  logic [16:0] rem_sh;
  logic [16:0] rem_sub;
  logic        fits;
  logic [16:0] rem_nxt;
  assign rem_sh  = {rem, dvd[DVD_W-1]};
  assign rem_sub = rem_sh - {1'b0, dsr};
  assign fits    = (rem_sh >= {1'b0, dsr});
  assign rem_nxt = fits ? rem_sub : rem_sh;

  // Final result formation for the FINISH state.
  logic signed [16:0] sum;
  logic [31:0]        mag;
  logic               neg;
  logic [15:0]        fin_result;
  logic               fin_ovf;
  logic               fin_dbz;

  always_comb begin
    sum        = 17'sd0;
    mag        = 32'd0;
    neg        = a_q[15] ^ b_q[15];
    fin_result = 16'd0;
    fin_ovf    = 1'b0;
    fin_dbz    = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        if (op_q == OP_ADD) sum = $signed({a_q[15], a_q}) + $signed({b_q[15], b_q});
        else                sum = $signed({a_q[15], a_q}) - $signed({b_q[15], b_q});
        // -32768 is excluded so the saturated range stays symmetric.
        if (sum > 17'sd32767) begin
          fin_result = POS_SAT;
          fin_ovf    = 1'b1;
        end else if (sum < -17'sd32767) begin
          fin_result = NEG_SAT;
          fin_ovf    = 1'b1;
        end else begin
          fin_result = sum[15:0];
        end
      end
      default: begin
        if (op_q == OP_MUL) mag = prod >> FRAC_BITS;
        else                mag = 32'(quo);
        if (op_q == OP_DIV && b_q == 16'd0) begin
          fin_result = a_q[15] ? NEG_SAT : POS_SAT;
          fin_dbz    = 1'b1;
        end else if (mag > 32'd32767) begin
          fin_result = neg ? NEG_SAT : POS_SAT;
          fin_ovf    = 1'b1;
        end else if (neg && mag != 32'd0) begin
          // Zero magnitude stays positive regardless of operand signs.
          fin_result = ~mag[15:0] + 16'd1;
        end else begin
          fin_result = mag[15:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= OP_ADD;
      a_q         <= 16'd0;
      b_q         <= 16'd0;
      cnt         <= 5'd0;
      mcand       <= 32'd0;
      mplier      <= 16'd0;
      prod        <= 32'd0;
      dsr         <= 16'd0;
      rem         <= 16'd0;
      dvd         <= '0;
      quo         <= '0;
      result      <= 16'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          // A start coinciding with done is deliberately not accepted.
          if (start && !done) begin
            op_q   <= op;
            a_q    <= operand_a;
            b_q    <= operand_b;
            busy   <= 1'b1;
            cnt    <= 5'd0;
            mcand  <= {16'd0, mag_a_in};
            mplier <= mag_b_in;
            prod   <= 32'd0;
            dsr    <= mag_b_in;
            rem    <= 16'd0;
            dvd    <= {mag_a_in, {FRAC_BITS{1'b0}}};
            quo    <= '0;
            if (op == OP_MUL)                            state <= S_MUL;
            else if (op == OP_DIV && operand_b != 16'd0) state <= S_DIV;
            else                                         state <= S_FINISH;
          end
        end
        S_MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == MUL_LAST) state <= S_FINISH;
        end
        S_DIV: begin
          rem <= rem_nxt[15:0];
          dvd <= dvd << 1;
          quo <= {quo[DVD_W-2:0], fits};
          cnt <= cnt + 5'd1;
          if (cnt == DIV_LAST) state <= S_FINISH;
        end
        S_FINISH: begin
          result      <= fin_result;
          overflow    <= fin_ovf;
          div_by_zero <= fin_dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          cnt         <= 5'd0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bits intentionally dropped by the divider step.
  logic unused_bits;
  assign unused_bits = rem_nxt[16];

endmodule

// File: tb/tb_fixed_point_alu.sv
// ----------------------------------------------------------------------------
// tb_fixed_point_alu
//
// Directed plus randomized bench for fixed_point_alu. Expected results come
// from a behavioural integer model and are queued when a request is driven,
// then popped and compared when done is observed.
// ----------------------------------------------------------------------------
module tb_fixed_point_alu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [15:0] result;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        div_by_zero;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // {result, overflow, div_by_zero}
  logic [17:0] exp_q[$];

  fixed_point_alu dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .result      (result),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    int    sa;
    int    sb;
    int    v;
    longint m;
    bit    ng;
    sa = int'($signed(a));
    sb = int'($signed(b));
    v  = 0;
    case (o)
      2'd0: v = sa + sb;
      2'd1: v = sa - sb;
      2'd2: begin
        m  = longint'(sa) * longint'(sb);
        ng = (m < 0);
        if (ng) m = -m;
        m = m / 64;
        v = ng ? -int'(m) : int'(m);
      end
      default: begin
        if (sb == 0) return {(sa >= 0) ? 16'h7FFF : 16'h8001, 1'b0, 1'b1};
        ng = ((sa < 0) != (sb < 0));
        m  = (longint'((sa < 0) ? -sa : sa) * 64) / longint'((sb < 0) ? -sb : sb);
        v  = ng ? -int'(m) : int'(m);
      end
    endcase
    if (v > 32767)  return {16'h7FFF, 1'b1, 1'b0};
    if (v < -32767) return {16'h8001, 1'b1, 1'b0};
    return {16'(v), 1'b0, 1'b0};
  endfunction

  function automatic int exp_latency(input logic [1:0] o, input logic [15:0] b);
    if (o == 2'd2) return 17;
    if (o == 2'd3 && b != 16'd0) return 23;
    return 1;
  endfunction

  // Drives one request and waits (bounded) for done. If glitch is set, a
  // second start with different operands is presented at edge 5.
  task automatic do_op(input string name, input logic [1:0] o,
                       input logic [15:0] a, input logic [15:0] b, input bit glitch);
    int          lat;
    int          n_exp;
    bit          busy_bad;
    logic [17:0] e;
    lat      = -1;
    busy_bad = 1'b0;
    n_exp    = exp_latency(o, b);
    exp_q.push_back(model(o, a, b));
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    @(posedge clk);  // edge 0
    #1;
    start     = 1'b0;
    operand_a = 16'($urandom_range(0, 65535));
    operand_b = 16'($urandom_range(0, 65535));
    op        = 2'($urandom_range(0, 3));
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_bad = 1'b1;
      if (glitch && k == 4) start = 1'b1;
    end
    check({name, " latency"}, 32'(lat), 32'(n_exp));
    check({name, " busy held"}, 32'(busy_bad), 32'd0);
    check({name, " busy at done"}, 32'(busy), 32'd0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({name, " result"}, 32'(result), 32'(e[17:2]));
      check({name, " overflow"}, 32'(overflow), 32'(e[1]));
      check({name, " div_by_zero"}, 32'(div_by_zero), 32'(e[0]));
    end
    // Start presented while done is high must be dropped.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, " done one cycle"}, 32'(done), 32'd0);
    check({name, " start at done ignored"}, 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  ro;
    logic [15:0] ra;
    logic [15:0] rb;
    bit          saw_done;

    rst       = 1'b1;
    start     = 1'b0;
    op        = 2'd0;
    operand_a = 16'd0;
    operand_b = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", 32'(result), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    do_op("add 1.5+2.25", 2'd0, 16'h0060, 16'h0090, 1'b0);
    check("add exact value", 32'(result), 32'h00F0);
    do_op("sub 1.5-2.25", 2'd1, 16'h0060, 16'h0090, 1'b0);
    check("sub exact value", 32'(result), 32'hFFD0);
    do_op("mul -1.5*2.25", 2'd2, 16'hFFA0, 16'h0090, 1'b0);
    check("mul exact value", 32'(result), 32'hFF28);
    do_op("div 3.75/1.5", 2'd3, 16'h00F0, 16'h0060, 1'b1);
    check("div exact value", 32'(result), 32'h00A0);
    do_op("add overflow", 2'd0, 16'h7F00, 16'h0200, 1'b0);
    check("add overflow value", 32'(result), 32'h7FFF);
    do_op("div by zero neg", 2'd3, 16'hFF00, 16'h0000, 1'b0);
    check("dbz value", 32'(result), 32'h8001);
    do_op("div by zero pos", 2'd3, 16'h0040, 16'h0000, 1'b0);
    do_op("sub to -32768", 2'd1, 16'h8001, 16'h0001, 1'b0);
    do_op("add -32768", 2'd0, 16'hC000, 16'hC000, 1'b0);
    do_op("mul -32768*1", 2'd2, 16'h8000, 16'h0040, 1'b0);
    do_op("mul overflow", 2'd2, 16'h4000, 16'h4000, 1'b0);
    do_op("mul zero neg", 2'd2, 16'hFFFF, 16'h0001, 1'b0);
    do_op("div overflow", 2'd3, 16'h7000, 16'h0001, 1'b0);
    do_op("div -32768/-1", 2'd3, 16'h8000, 16'hFFC0, 1'b0);
    do_op("div trunc neg", 2'd3, 16'hFFFF, 16'h0060, 1'b0);

    // Reset in the middle of a multiply
    start     = 1'b1;
    op        = 2'd2;
    operand_a = 16'h0100;
    operand_b = 16'h0100;
    @(posedge clk);  // edge 0
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);  // edge 8
    #1;
    check("mid-op busy before reset", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid-op reset result", 32'(result), 32'd0);
    check("mid-op reset busy", 32'(busy), 32'd0);
    check("mid-op reset flags", 32'({overflow, div_by_zero, done}), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("no done after abort", 32'(saw_done), 32'd0);
    do_op("add after reset", 2'd0, 16'h0040, 16'h0040, 1'b0);
    check("add after reset value", 32'(result), 32'h0080);

    // Randomized requests
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        ra = 16'($urandom_range(0, 65535));
        rb = 16'($urandom_range(0, 65535));
      end else begin
        ra = 16'($signed(11'($urandom_range(0, 2047))));
        rb = 16'($signed(10'($urandom_range(0, 1023))));
      end
      if (ro == 2'd3 && $urandom_range(0, 7) == 0) rb = 16'd0;
      do_op("random op", ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
